ic: RTL and testbench



---
 rtl/ic_pkg.sv | 36 +++
 rtl/ic_vc_fifo.sv | 58 +++++
 rtl/ic.sv | 165 ++++++++++++++++
 tb/tb_ic.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ic_pkg.sv
// Shared definitions for the hypercube router input channel: default geometry,
// flit type encoding and field positions.
package ic_pkg;

    localparam int unsigned IC_DATA_WIDTH    = 32;
    localparam int unsigned IC_VCH_WIDTH_NUM = 1;
    localparam int unsigned IC_PORT_NUM      = 5;
    localparam int unsigned IC_ADDR_W        = 4;
    localparam int unsigned IC_DEPTH         = 4;

    // Type field occupies the top TYPE_W bits of a flit; dest sits at the bottom.
    localparam int unsigned TYPE_W  = 2;
    localparam int unsigned DEST_LO = 0;

    typedef enum logic [1:0] {
        FLIT_BODY   = 2'b00,
        FLIT_HEAD   = 2'b01,
        FLIT_TAIL   = 2'b10,
        FLIT_SINGLE = 2'b11
    } flit_type_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUTE,
        ST_SEND
    } ic_state_t;

    function automatic logic is_head(input flit_type_t t);
        return (t == FLIT_HEAD) || (t == FLIT_SINGLE);
    endfunction

    function automatic logic is_tail(input flit_type_t t);
        return (t == FLIT_TAIL) || (t == FLIT_SINGLE);
    endfunction

endpackage

// File: rtl/ic_vc_fifo.sv
// Per-virtual-channel flit buffer. A pop in the same cycle as a push frees the
// slot, so a full FIFO still accepts a write when it is being drained.
module vc_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + (PTR_W+1)'(1);
            end else if (do_pop && !do_push) begin
                count <= count - (PTR_W+1)'(1);
            end
        end
    end

endmodule

// File: rtl/ic.sv
// Hypercube router input channel: per-VC buffering, e-cube route selection from
// the head flit, crossbar request and wormhole streaming, upstream credit return.
module ic
    import ic_pkg::*;
#(
    parameter int unsigned       DATA_WIDTH    = IC_DATA_WIDTH,
    parameter int unsigned       VCH_WIDTH_NUM = IC_VCH_WIDTH_NUM,
    parameter int unsigned       PORT_NUM      = IC_PORT_NUM,
    parameter int unsigned       ADDR_W        = IC_ADDR_W,
    parameter logic [ADDR_W-1:0] NODE_ID       = '0,
    parameter int unsigned       DEPTH         = IC_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_WIDTH-1:0]    idata,
    input  logic                     ivalid,
    input  logic [VCH_WIDTH_NUM-1:0] ivch,
    output logic                     ocredit,
    output logic [VCH_WIDTH_NUM-1:0] ocredit_vch,
    output logic [DATA_WIDTH-1:0]    odata,
    output logic                     ovalid,
    output logic [VCH_WIDTH_NUM-1:0] ovch,
    output logic [PORT_NUM-1:0]      port,
    output logic                     req,
    input  logic [PORT_NUM-1:0]      grt,
    output logic                     overflow_err
);

    localparam int unsigned NUM_VC = 2 ** VCH_WIDTH_NUM;

    ic_state_t                state;
    ic_state_t                state_next;
    logic [VCH_WIDTH_NUM-1:0] cur_vc;
    logic [VCH_WIDTH_NUM-1:0] rr_ptr;
    logic [VCH_WIDTH_NUM-1:0] pick_vc;
    logic [VCH_WIDTH_NUM-1:0] cand_vc;
    logic                     pick_valid;
    logic [PORT_NUM-1:0]      port_q;
    logic                     fire;
    logic                     overflow_set;
    logic [DATA_WIDTH-1:0]    head_data [NUM_VC];
    logic [NUM_VC-1:0]        fifo_push;
    logic [NUM_VC-1:0]        fifo_pop;
    logic [NUM_VC-1:0]        fifo_full;
    logic [NUM_VC-1:0]        fifo_empty;

    function automatic flit_type_t flit_type(input logic [DATA_WIDTH-1:0] f);
        return flit_type_t'(f[DATA_WIDTH-1 -: TYPE_W]);
    endfunction

    // e-cube: correct the lowest differing address bit first; no difference is local.
    function automatic logic [PORT_NUM-1:0] route(input logic [ADDR_W-1:0] dest);
        logic [ADDR_W-1:0]   diff;
        logic [PORT_NUM-1:0] sel;
        logic                found;
        diff  = dest ^ NODE_ID;
        sel   = '0;
        found = 1'b0;
        if (diff == '0) begin
            sel[0] = 1'b1;
        end else begin
            for (int unsigned d = 0; d < ADDR_W; d++) begin
                if (diff[d] && !found) begin
                    sel[d+1] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
        return sel;
    endfunction

    for (genvar g = 0; g < NUM_VC; g++) begin : g_vc
        assign fifo_push[g] = ivalid && (ivch == VCH_WIDTH_NUM'(g));
        assign fifo_pop[g]  = fire && (cur_vc == VCH_WIDTH_NUM'(g));

        vc_fifo #(
            .WIDTH (DATA_WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (fifo_push[g]),
            .wdata (idata),
            .pop   (fifo_pop[g]),
            .rdata (head_data[g]),
            .full  (fifo_full[g]),
            .empty (fifo_empty[g])
        );
    end

    assign overflow_set = ivalid && fifo_full[ivch] && !fifo_pop[ivch];

    // Round-robin search starting at rr_ptr for a VC whose buffered head opens a packet.
    always_comb begin
        pick_valid = 1'b0;
        pick_vc    = rr_ptr;
        cand_vc    = rr_ptr;
        for (int unsigned i = 0; i < NUM_VC; i++) begin
            cand_vc = rr_ptr + VCH_WIDTH_NUM'(i);
            if (!pick_valid && !fifo_empty[cand_vc] && is_head(flit_type(head_data[cand_vc]))) begin
                pick_valid = 1'b1;
                pick_vc    = cand_vc;
            end
        end
    end

    always_comb begin
        state_next = state;
        fire       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_next = ST_ROUTE;
                end
            end
            ST_ROUTE: begin
                state_next = ST_SEND;
            end
            ST_SEND: begin
                fire = (|(grt & port_q)) && !fifo_empty[cur_vc];
                if (fire && is_tail(flit_type(head_data[cur_vc]))) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign req    = (state == ST_SEND);
    assign port   = port_q;
    assign ovalid = fire;
    assign odata  = fire ? head_data[cur_vc] : '0;
    assign ovch   = fire ? cur_vc : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            cur_vc       <= '0;
            rr_ptr       <= '0;
            port_q       <= '0;
            ocredit      <= 1'b0;
            ocredit_vch  <= '0;
            overflow_err <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && pick_valid) begin
                cur_vc <= pick_vc;
                rr_ptr <= pick_vc + 1'b1;
            end
            if (state == ST_ROUTE) begin
                port_q <= route(head_data[cur_vc][DEST_LO +: ADDR_W]);
            end
            ocredit <= fire;
            if (fire) begin
                ocredit_vch <= cur_vc;
            end
            if (overflow_set) begin
                overflow_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ic.sv
// Self-checking bench for ic: directed scenarios plus randomized traffic checked
// against a queue-based model of per-VC buffering, e-cube routing and credits.
module tb_ic;

    localparam int         DEPTH = 4;
    localparam logic [3:0] NODE  = 4'b0101;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] idata = '0;
    logic        ivalid = 1'b0;
    logic [0:0]  ivch = '0;
    logic        ocredit;
    logic [0:0]  ocredit_vch;
    logic [31:0] odata;
    logic        ovalid;
    logic [0:0]  ovch;
    logic [4:0]  port;
    logic        req;
    logic [4:0]  grt;
    logic        overflow_err;
    logic        grt_en = 1'b0;
    logic [4:0]  noise = '0;

    assign grt = grt_en ? port : (noise & ~port);

    always #5 clk = ~clk;

    ic #(
        .DATA_WIDTH    (32),
        .VCH_WIDTH_NUM (1),
        .PORT_NUM      (5),
        .ADDR_W        (4),
        .NODE_ID       (NODE),
        .DEPTH         (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .idata        (idata),
        .ivalid       (ivalid),
        .ivch         (ivch),
        .ocredit      (ocredit),
        .ocredit_vch  (ocredit_vch),
        .odata        (odata),
        .ovalid       (ovalid),
        .ovch         (ovch),
        .port         (port),
        .req          (req),
        .grt          (grt),
        .overflow_err (overflow_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // e-cube reference: divide out the XOR distance until its lowest set bit appears.
    function automatic logic [4:0] ref_route(input logic [3:0] dest);
        int diff;
        int d;
        diff = int'(dest ^ NODE);
        d    = 0;
        if (diff == 0) return 5'd1;
        while (diff % 2 == 0) begin
            diff = diff / 2;
            d++;
        end
        return 5'(1 << (d + 1));
    endfunction

    function automatic logic [31:0] mk(input logic [1:0] t, input logic [3:0] dest);
        logic [25:0] pl;
        pl = 26'($urandom);
        return {t, pl, dest};
    endfunction

    typedef logic [31:0] flitq_t [$];
    flitq_t     mq [2];
    bit         ov_exp = 0;
    bit         cred_pend = 0;
    logic [0:0] cred_vch_exp = '0;
    bit         in_pkt = 0;
    logic [0:0] pkt_vc = '0;
    logic [4:0] pkt_port = '0;
    int         out_cnt = 0;
    int         cred_cnt [2] = '{0, 0};
    logic [0:0] out_vc_log [$];

    // Each negedge checks outputs against the model, then applies the coming edge.
    always @(negedge clk) begin
        logic [31:0] f;
        if (reset) begin
            mq[0].delete();
            mq[1].delete();
            ov_exp    = 0;
            cred_pend = 0;
            in_pkt    = 0;
        end else begin
            check("overflow_err", overflow_err, ov_exp);
            check("ocredit", ocredit, cred_pend);
            if (cred_pend) check("ocredit_vch", ocredit_vch, cred_vch_exp);
            if (ocredit) cred_cnt[ocredit_vch]++;
            if (!ovalid) begin
                check("odata_idle", odata, 0);
                if (req && ((grt & port) != 0) && in_pkt && mq[pkt_vc].size() > 0)
                    check("stall_fire", ovalid, 1);
            end else begin
                check("req_with_ovalid", req, 1);
                check("grant_with_ovalid", |(grt & port), 1);
                if (mq[ovch].size() == 0) begin
                    check("unexpected_flit", ovalid, 0);
                end else begin
                    f = mq[ovch].pop_front();
                    check("odata", odata, f);
                    if (f[30]) begin
                        check("head_in_pkt", in_pkt, 0);
                        check("route", port, ref_route(f[3:0]));
                        pkt_vc   = ovch;
                        pkt_port = port;
                    end else begin
                        check("pkt_open", in_pkt, 1);
                        check("ovch_stable", ovch, pkt_vc);
                        check("port_stable", port, pkt_port);
                    end
                    in_pkt = !f[31];
                    out_cnt++;
                    out_vc_log.push_back(ovch);
                end
            end
            cred_pend    = ovalid;
            cred_vch_exp = ovch;
            if (ivalid) begin
                if (mq[ivch].size() < DEPTH) mq[ivch].push_back(idata);
                else ov_exp = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        ivalid = 1'b0;
        grt_en = 1'b0;
        noise  = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic write(input int vc, input logic [31:0] f);
        ivch   = 1'(vc);
        idata  = f;
        ivalid = 1'b1;
        tick();
        ivalid = 1'b0;
    endtask

    task automatic route_single(input string tag, input logic [3:0] dest, input logic [4:0] exp_port);
        logic [31:0] f;
        f = mk(2'b11, dest);
        write(0, f);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check({tag, "_port"}, port, exp_port);
        check({tag, "_ovalid"}, ovalid, 1);
        check({tag, "_odata"}, odata, f);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [31:0] f;
        logic [31:0] tl;
        int          c0, c1, o;
        int          rr_exp [5];
        int          rem [2];
        int          len, v, k;
        logic [3:0]  dst [2];
        bit          gen_on, done;

        // Reset values
        do_reset();
        @(negedge clk);
        check("rst_req", req, 0);
        check("rst_port", port, 0);
        check("rst_ovalid", ovalid, 0);
        check("rst_odata", odata, 0);
        check("rst_ovch", ovch, 0);
        check("rst_ocredit", ocredit, 0);
        check("rst_ocredit_vch", ocredit_vch, 0);
        check("rst_overflow", overflow_err, 0);
        tick();

        // Single flit: three-cycle latency, credit next cycle, req drops after
        grt_en = 1'b1;
        f = mk(2'b11, 4'b0100);
        write(0, f);
        @(negedge clk); check("t1_pick_req", req, 0);
        @(negedge clk); check("t1_route_req", req, 0);
        @(negedge clk);
        check("t1_port", port, 5'b00010);
        check("t1_req", req, 1);
        check("t1_ovalid", ovalid, 1);
        check("t1_odata", odata, f);
        check("t1_ovch", ovch, 0);
        @(negedge clk);
        check("t1_ocredit", ocredit, 1);
        check("t1_ocredit_vch", ocredit_vch, 0);
        check("t1_req_low", req, 0);
        tick();

        route_single("t2_local", 4'b0101, 5'b00001);
        route_single("t2_dim3", 4'b1101, 5'b10000);
        route_single("t2_dim1", 4'b0111, 5'b00100);
        route_single("t2_dim2", 4'b1001, 5'b01000);

        // Four-flit packet on VC1 with a two-cycle grant gap
        do_reset();
        grt_en = 1'b1;
        c0 = cred_cnt[0]; c1 = cred_cnt[1]; o = out_cnt;
        write(1, mk(2'b01, 4'b1101));
        write(1, mk(2'b00, 4'($urandom)));
        write(1, mk(2'b00, 4'($urandom)));
        write(1, mk(2'b10, 4'($urandom)));
        tick();
        grt_en = 1'b0;
        @(negedge clk); check("t3_gap1_ovalid", ovalid, 0);
        check("t3_gap1_req", req, 1);
        tick();
        @(negedge clk); check("t3_gap2_ovalid", ovalid, 0);
        tick();
        grt_en = 1'b1;
        repeat (6) tick();
        check("t3_flits", out_cnt - o, 4);
        check("t3_credits_vc1", cred_cnt[1] - c1, 4);
        check("t3_credits_vc0", cred_cnt[0] - c0, 0);

        // Round-robin alternation between VCs
        do_reset();
        out_vc_log.delete();
        write(1, mk(2'b11, 4'($urandom)));
        write(1, mk(2'b11, 4'($urandom)));
        write(1, mk(2'b11, 4'($urandom)));
        write(0, mk(2'b11, 4'($urandom)));
        write(0, mk(2'b11, 4'($urandom)));
        grt_en = 1'b1;
        repeat (25) tick();
        rr_exp = '{1, 0, 1, 0, 1};
        check("t4_count", out_vc_log.size(), 5);
        for (int i = 0; i < 5 && i < out_vc_log.size(); i++)
            check($sformatf("t4_order%0d", i), out_vc_log[i], rr_exp[i]);

        // Overflow on a full VC, sticky until reset
        do_reset();
        write(0, mk(2'b01, 4'($urandom)));
        repeat (3) write(0, mk(2'b00, 4'($urandom)));
        @(negedge clk); check("t5_full_no_err", overflow_err, 0);
        tick();
        write(0, mk(2'b10, 4'($urandom)));
        @(negedge clk); check("t5_overflow", overflow_err, 1);
        repeat (3) tick();
        @(negedge clk); check("t5_sticky", overflow_err, 1);
        tick();

        // Push and pop together on a full VC is not an overflow
        do_reset();
        o = out_cnt;
        write(0, mk(2'b01, 4'($urandom)));
        repeat (3) write(0, mk(2'b00, 4'($urandom)));
        tick();
        tick();
        grt_en = 1'b1;
        tl = mk(2'b10, 4'($urandom));
        write(0, tl);
        @(negedge clk); check("t5_pushpop_no_err", overflow_err, 0);
        repeat (8) tick();
        check("t5_pushpop_flits", out_cnt - o, 5);
        check("t5_pushpop_err_end", overflow_err, 0);

        // Reset in the middle of a packet
        do_reset();
        grt_en = 1'b1;
        write(1, mk(2'b01, 4'b0100));
        write(1, mk(2'b00, 4'($urandom)));
        write(1, mk(2'b00, 4'($urandom)));
        write(1, mk(2'b10, 4'($urandom)));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("t6_req", req, 0);
        check("t6_ovalid", ovalid, 0);
        check("t6_ocredit", ocredit, 0);
        check("t6_port", port, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t6_empty", ovalid, 0);
        end
        tick();
        route_single("t6_after", 4'b1101, 5'b10000);

        // Randomized traffic, then drain
        do_reset();
        rem    = '{0, 0};
        dst    = '{4'd0, 4'd0};
        gen_on = 1;
        for (int cyc = 0; cyc < 3400; cyc++) begin
            ivalid = 1'b0;
            if (cyc >= 3000) gen_on = 0;
            if ($urandom_range(0, 3) != 0) begin
                v = $urandom_range(0, 1);
                if (mq[v].size() < DEPTH && (rem[v] > 0 || gen_on)) begin
                    if (rem[v] == 0) begin
                        len    = $urandom_range(1, 5);
                        dst[v] = 4'($urandom);
                        f      = mk((len == 1) ? 2'b11 : 2'b01, dst[v]);
                        rem[v] = len - 1;
                    end else begin
                        rem[v]--;
                        f = mk((rem[v] == 0) ? 2'b10 : 2'b00, 4'($urandom));
                    end
                    ivch   = 1'(v);
                    idata  = f;
                    ivalid = 1'b1;
                end
            end
            grt_en = gen_on ? ($urandom_range(0, 3) != 0) : 1'b1;
            noise  = 5'($urandom);
            tick();
        end
        ivalid = 1'b0;
        grt_en = 1'b1;
        k      = 0;
        done   = 0;
        while (k < 400 && !done) begin
            tick();
            done = (mq[0].size() == 0) && (mq[1].size() == 0) && !in_pkt &&
                   (rem[0] == 0) && (rem[1] == 0);
            k++;
        end
        check("drain_done", done, 1);
        check("random_overflow", overflow_err, 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
